id_stage: RTL and testbench
===========================

# id_stage

Instruction decode and operand-fetch stage that sits directly upstream of the ALU top-level block. It accepts a 32-bit MIPS-style instruction, reads a 32x32 register file, and produces the ALU's `opcode`, `func_field`, `A` and `B` plus a destination tag in a registered ID/EX output slot with a valid/ready handshake. It also owns the writeback port into the register file and a per-register busy scoreboard that stalls read-after-write hazards.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index, 32 registers.
- `clk` in 1: single clock, all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: instruction on `instr` is offered.
- `instr` in 32: the instruction word, with fields opcode[31:26], rs[25:21], rt[20:16], rd[15:11], func[5:0], imm[15:0].
- `instr_ready` out 1: the stage accepts `instr` this cycle. Combinational.
- `ex_valid` out 1: the ID/EX slot holds an operation.
- `ex_ready` in 1: the downstream ALU/EX stage consumes the slot this cycle.
- `ex_opcode` out 6: drives ALU `opcode`.
- `ex_func_field` out 6: drives ALU `func_field`.
- `ex_A` out 32: drives ALU `A`.
- `ex_B` out 32: drives ALU `B`.
- `ex_dest` out 5: destination register index.
- `ex_dest_en` out 1: the operation writes back.
- `wb_en` in 1: write request.
- `wb_addr` in 5: write register index.
- `wb_data` in 32: write data.

## Operation
- **Register file.** 32 x 32 bits. r0 always reads 0. Writes to r0 are ignored, and a write to r0 does not touch the scoreboard.
- **Write-through bypass.** If `wb_en` is high and `wb_addr` equals rs or rt (nonzero), the read returns `wb_data` in the same cycle.
- **Decode by opcode:**
  - 0x00 (R-type): A=rs, B=rt, dest=rd, dest_en=1. func passed through.
  - 0x08 addi and 0x0A slti: A=rs, B=sign-extended imm, dest=rt, dest_en=1.
  - 0x0C andi and 0x0D ori: A=rs, B=zero-extended imm, dest=rt, dest_en=1.
  - 0x23 lw: A=rs, B=sign-extended imm, dest=rt, dest_en=1.
  - 0x2B sw: A=rs, B=sign-extended imm, dest_en=0.
  - 0x04 beq: A=rs, B=rt, dest_en=0.
  - Any other opcode: A=rs, B=rt, dest_en=0. `ex_opcode` and `ex_func_field` pass through unchanged.
  - An instruction with dest index 0 has `ex_dest_en` forced to 0.
- **Sources used:** R-type and beq read rs and rt. All other opcodes read rs only.
- **Scoreboard.** One busy bit per register (r1–r31).
  - Set when an instruction with `ex_dest_en=1` is accepted.
  - Cleared when `wb_en` writes that register.
  - If set and clear hit the same register in the same cycle, set wins.
- **Hazard.** Asserted when any used source is busy and is not being cleared by `wb_en` this cycle.
- **Handshake.**
  - `instr_ready = (!ex_valid || ex_ready) && !hazard`.
  - Accept = `instr_valid && instr_ready`. On accept, the ID/EX slot loads the decoded fields and `ex_valid` is 1 next cycle.
  - If `ex_ready` is high with no accept, `ex_valid` goes to 0 next cycle.
  - While `ex_valid && !ex_ready`, all `ex_*` outputs hold stable.
  - `instr_ready` may be asserted while `instr_valid` is low. It is a function of the presented `instr`.

## Timing
- Latency is 1 cycle from accept to `ex_valid`.
- Throughput is 1 instruction per cycle when there is no hazard and `ex_ready` is held high.
- Register write is visible to a read in the same cycle (bypass) and in every later cycle.
- **Reset.** While `reset` is high, at the rising edge:
  - all registers are cleared to 0 and all busy bits cleared;
  - `ex_valid`=0, `ex_opcode`/`ex_func_field`=0, `ex_A`/`ex_B`=0, `ex_dest`=0, `ex_dest_en`=0;
  - `instr_ready` is 0 during reset;
  - `wb_en` and accepts are ignored.
- **Reset mid-operation.** An in-flight ID/EX operation is dropped. No writeback occurs that cycle.
- **Simultaneous consume and accept.** When `ex_ready` and accept occur in the same cycle, the slot is replaced with no bubble.

## Test plan
- **Reset.** Hold `reset` 2 cycles, then read r1..r31 via R-type instructions. Required: `ex_A`=`ex_B`=0, `ex_valid`=0 during reset, `instr_ready`=0 during reset.
- **Writeback and R-type decode.**
  - Stimulus: write r3=0x0000_0005 and r4=0xFFFF_FFFE, then issue add r5,r3,r4 (0x00642820).
  - Required next cycle: `ex_valid`=1, `ex_opcode`=0, `ex_func_field`=0x20, `ex_A`=5, `ex_B`=0xFFFFFFFE, `ex_dest`=5, `ex_dest_en`=1.
- **Immediate extension.**
  - Stimulus: addi r2,r1,-1 (imm 0xFFFF), then ori r2,r1,0xFFFF.
  - Required: `ex_B`=0xFFFFFFFF for addi, then 0x0000FFFF for ori, with `ex_dest`=2 for both.
- **RAW stall.**
  - Stimulus: accept add r5,...; then present sub r6,r5,r4.
  - Required: `instr_ready`=0 until `wb_en`=1 with `wb_addr`=5. In that wb cycle the instruction is accepted and `ex_A` equals the bypassed `wb_data`.
- **Backpressure.**
  - Stimulus: hold `ex_ready`=0 for 3 cycles with `instr_valid`=1.
  - Required: `ex_*` stable, `instr_ready`=0, no instruction lost. Raise `ex_ready` and back-to-back issue proceeds at 1 per cycle.
- **r0 and same-cycle set/clear.**
  - Stimulus: wb to r0 with 0x1234, then read r0.
  - Required: 0.
  - Stimulus: accept an instruction with dest=7 in the same cycle as a wb to r7.
  - Required: r7 remains busy.

Source files
------------

// File: rtl/id_stage.sv
// Decode/operand-fetch stage: 32x32 regfile, busy scoreboard, registered ID/EX slot for the ALU.
// Latency: 1 cycle from accept to ex_valid; write-through bypass makes a writeback visible the same cycle.
// Backpressure: instr_ready drops while the slot is held (ex_valid && !ex_ready) or a used source is busy.
module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_func_field,
    output logic [31:0] ex_A,
    output logic [31:0] ex_B,
    output logic [4:0]  ex_dest,
    output logic        ex_dest_en,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  func_field;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        dest_en;
    } ex_slot_t;

    logic [31:0] regs [32];
    logic [31:0] busy_q;
    logic [31:0] busy_d;
    ex_slot_t    slot_q;
    ex_slot_t    dec;

    logic [5:0]  op;
    logic [4:0]  rs_idx;
    logic [4:0]  rt_idx;
    logic [4:0]  rd_idx;
    logic [15:0] imm;
    logic [31:0] rs_dat;
    logic [31:0] rt_dat;
    logic        rs_clr;
    logic        rt_clr;
    logic        uses_rt;
    logic        hazard;
    logic        accept;
    logic        wb_live;

    assign op     = instr[31:26];
    assign rs_idx = instr[25:21];
    assign rt_idx = instr[20:16];
    assign rd_idx = instr[15:11];
    assign imm    = instr[15:0];

    assign wb_live = wb_en && (wb_addr != 5'd0);
    assign rs_clr  = wb_live && (wb_addr == rs_idx);
    assign rt_clr  = wb_live && (wb_addr == rt_idx);

    // r0 is hardwired to zero, so it never bypasses and never reads the array.
    assign rs_dat = (rs_idx == 5'd0) ? 32'd0 : (rs_clr ? wb_data : regs[rs_idx]);
    assign rt_dat = (rt_idx == 5'd0) ? 32'd0 : (rt_clr ? wb_data : regs[rt_idx]);

    always_comb begin
        dec            = '0;
        uses_rt        = 1'b0;
        dec.opcode     = op;
        dec.func_field = instr[5:0];
        dec.a          = rs_dat;
        dec.b          = rt_dat;
        dec.dest       = rt_idx;
        dec.dest_en    = 1'b0;
        case (op)
            OP_RTYPE: begin
                uses_rt     = 1'b1;
                dec.dest    = rd_idx;
                dec.dest_en = 1'b1;
            end
            OP_BEQ: uses_rt = 1'b1;
            OP_ADDI, OP_SLTI, OP_LW: begin
                dec.b       = {{16{imm[15]}}, imm};
                dec.dest_en = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec.b       = {16'd0, imm};
                dec.dest_en = 1'b1;
            end
            OP_SW: dec.b = {{16{imm[15]}}, imm};
            default: ;
        endcase
        if (dec.dest == 5'd0) begin
            dec.dest_en = 1'b0;
        end
    end

    // busy_q[0] is never set, so r0 sources can never stall.
    assign hazard = (busy_q[rs_idx] && !rs_clr) ||
                    (uses_rt && busy_q[rt_idx] && !rt_clr);

    assign instr_ready = !reset && (!ex_valid || ex_ready) && !hazard;
    assign accept      = instr_valid && instr_ready;

    // Set is applied after clear so a same-cycle set/clear leaves the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_live) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (accept && dec.dest_en) begin
            busy_d[dec.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
            busy_q   <= '0;
            ex_valid <= 1'b0;
            slot_q   <= '0;
        end else begin
            if (wb_live) begin
                regs[wb_addr] <= wb_data;
            end
            busy_q <= busy_d;
            if (accept) begin
                slot_q   <= dec;
                ex_valid <= 1'b1;
            end else if (ex_ready) begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign ex_opcode     = slot_q.opcode;
    assign ex_func_field = slot_q.func_field;
    assign ex_A          = slot_q.a;
    assign ex_B          = slot_q.b;
    assign ex_dest       = slot_q.dest;
    assign ex_dest_en    = slot_q.dest_en;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: reference model of regfile/scoreboard/slot compared every cycle, plus directed literal checks.
module tb_id_stage;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_func_field;
    logic [31:0] ex_A;
    logic [31:0] ex_B;
    logic [4:0]  ex_dest;
    logic        ex_dest_en;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    id_stage dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_opcode     (ex_opcode),
        .ex_func_field (ex_func_field),
        .ex_A          (ex_A),
        .ex_B          (ex_B),
        .ex_dest       (ex_dest),
        .ex_dest_en    (ex_dest_en),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  func;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        den;
    } exp_t;

    logic [31:0] m_regs [32];
    bit          m_busy [32];
    bit          exp_valid = 1'b0;
    exp_t        exp_slot;
    exp_t        m_dec;
    bit          m_acc;

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 32'd0;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic bit two_src(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h04);
    endfunction

    function automatic bit blocked(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(wb_en && wb_addr == r);
    endfunction

    function automatic bit m_ready();
        if (reset) return 1'b0;
        if (exp_valid && !ex_ready) return 1'b0;
        if (blocked(instr[25:21])) return 1'b0;
        if (two_src(instr[31:26]) && blocked(instr[20:16])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t m_decode(input logic [31:0] w);
        exp_t e;
        logic [31:0] sext;
        logic [31:0] zext;
        sext   = {{16{w[15]}}, w[15:0]};
        zext   = {16'd0, w[15:0]};
        e.op   = w[31:26];
        e.func = w[5:0];
        e.a    = m_read(w[25:21]);
        e.b    = m_read(w[20:16]);
        e.dest = w[20:16];
        e.den  = 1'b0;
        if (e.op == 6'h00) begin
            e.dest = w[15:11];
            e.den  = 1'b1;
        end else if (e.op == 6'h08 || e.op == 6'h0A || e.op == 6'h23) begin
            e.b   = sext;
            e.den = 1'b1;
        end else if (e.op == 6'h0C || e.op == 6'h0D) begin
            e.b   = zext;
            e.den = 1'b1;
        end else if (e.op == 6'h2B) begin
            e.b = sext;
        end
        if (e.dest == 0) e.den = 1'b0;
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_busy[i] = 1'b0;
            end
            exp_valid = 1'b0;
        end else begin
            m_acc = instr_valid && m_ready();
            m_dec = m_decode(instr);
            if (wb_en && wb_addr != 0) begin
                m_regs[wb_addr] = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (m_acc) begin
                if (m_dec.den) m_busy[m_dec.dest] = 1'b1;
                exp_slot  = m_dec;
                exp_valid = 1'b1;
            end else if (ex_ready) begin
                exp_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_instr_ready", instr_ready, m_ready());
        chk("cmp_ex_valid", ex_valid, exp_valid);
        if (exp_valid) begin
            chk("cmp_opcode", ex_opcode, exp_slot.op);
            chk("cmp_func", ex_func_field, exp_slot.func);
            chk("cmp_A", ex_A, exp_slot.a);
            chk("cmp_B", ex_B, exp_slot.b);
            chk("cmp_dest_en", ex_dest_en, exp_slot.den);
            if (exp_slot.den) chk("cmp_dest", ex_dest, exp_slot.dest);
        end
    end

    // ---------------- directed stimulus ----------------
    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl_ins  [4];
    logic [31:0] tbl_b    [4];
    logic        tbl_den  [4];

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = mk_r(5'd1, 5'd2, 5'd3, 6'h20);
        ex_ready    = 1'b1;
        wb_en       = 1'b1;
        wb_addr     = 5'd9;
        wb_data     = 32'hDEAD_BEEF;

        // Reset: accepts and writebacks ignored.
        for (int k = 0; k < 2; k++) begin
            step();
            chk("rst_instr_ready", instr_ready, 1'b0);
            chk("rst_ex_valid", ex_valid, 1'b0);
            chk("rst_ex_A", ex_A, 32'd0);
        end
        reset = 1'b0;
        wb_en = 1'b0;

        for (int i = 1; i < 32; i++) begin
            instr = mk_r(i[4:0], i[4:0], 5'd0, 6'h20);
            step();
            chk("read_zero_A", ex_A, 32'd0);
            chk("read_zero_B", ex_B, 32'd0);
        end

        // Writeback then add r5,r3,r4.
        instr_valid = 1'b0;
        wb_en   = 1'b1;
        wb_addr = 5'd3;
        wb_data = 32'h0000_0005;
        step();
        wb_addr = 5'd4;
        wb_data = 32'hFFFF_FFFE;
        step();
        wb_en       = 1'b0;
        instr       = 32'h0064_2820;
        instr_valid = 1'b1;
        step();
        chk("add_valid", ex_valid, 1'b1);
        chk("add_opcode", ex_opcode, 6'h00);
        chk("add_func", ex_func_field, 6'h20);
        chk("add_A", ex_A, 32'h0000_0005);
        chk("add_B", ex_B, 32'hFFFF_FFFE);
        chk("add_dest", ex_dest, 5'd5);
        chk("add_dest_en", ex_dest_en, 1'b1);

        // Immediate extension.
        instr = mk_i(6'h08, 5'd1, 5'd2, 16'hFFFF);
        step();
        chk("addi_B", ex_B, 32'hFFFF_FFFF);
        chk("addi_dest", ex_dest, 5'd2);
        instr = mk_i(6'h0D, 5'd1, 5'd2, 16'hFFFF);
        step();
        chk("ori_B", ex_B, 32'h0000_FFFF);
        chk("ori_dest", ex_dest, 5'd2);

        // RAW stall on r5 until its writeback, then bypass.
        instr = mk_r(5'd5, 5'd4, 5'd6, 6'h22);
        #1 chk("raw_ready0", instr_ready, 1'b0);
        step();
        chk("raw_ready1", instr_ready, 1'b0);
        step();
        chk("raw_ready2", instr_ready, 1'b0);
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h0000_0077;
        #1 chk("raw_ready_wb", instr_ready, 1'b1);
        step();
        wb_en = 1'b0;
        chk("raw_A_bypass", ex_A, 32'h0000_0077);
        chk("raw_B", ex_B, 32'hFFFF_FFFE);
        chk("raw_func", ex_func_field, 6'h22);
        chk("raw_dest", ex_dest, 5'd6);

        // Backpressure for 3 cycles with a ready-to-go instruction waiting.
        ex_ready = 1'b0;
        instr    = mk_i(6'h08, 5'd0, 5'd8, 16'h0011);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_ready", instr_ready, 1'b0);
            chk("bp_valid", ex_valid, 1'b1);
            chk("bp_hold_A", ex_A, 32'h0000_0077);
            chk("bp_hold_dest", ex_dest, 5'd6);
            step();
        end
        ex_ready = 1'b1;
        #1 chk("bp_release_ready", instr_ready, 1'b1);
        step();
        chk("b2b_dest8", ex_dest, 5'd8);
        chk("b2b_B8", ex_B, 32'h0000_0011);
        instr = mk_i(6'h08, 5'd0, 5'd9, 16'h0001);
        step();
        chk("b2b_dest9", ex_dest, 5'd9);
        instr = mk_i(6'h08, 5'd0, 5'd10, 16'h0002);
        step();
        chk("b2b_dest10", ex_dest, 5'd10);
        chk("b2b_valid", ex_valid, 1'b1);

        // sw / lw / beq / unknown opcode decode.
        tbl_ins[0] = mk_i(6'h2B, 5'd3, 5'd5, 16'h8000); tbl_b[0] = 32'hFFFF_8000; tbl_den[0] = 1'b0;
        tbl_ins[1] = mk_i(6'h23, 5'd0, 5'd13, 16'h7FFF); tbl_b[1] = 32'h0000_7FFF; tbl_den[1] = 1'b1;
        tbl_ins[2] = mk_i(6'h04, 5'd3, 5'd4, 16'h0010);  tbl_b[2] = 32'hFFFF_FFFE; tbl_den[2] = 1'b0;
        tbl_ins[3] = mk_i(6'h3F, 5'd0, 5'd3, 16'h0042);  tbl_b[3] = 32'h0000_0005; tbl_den[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            instr = tbl_ins[k];
            step();
            chk("tbl_B", ex_B, tbl_b[k]);
            chk("tbl_dest_en", ex_dest_en, tbl_den[k]);
            chk("tbl_opcode", ex_opcode, tbl_ins[k][31:26]);
        end
        chk("unk_func", ex_func_field, 6'h02);

        // r0 ignores writes.
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = 32'h0000_1234;
        instr   = mk_r(5'd0, 5'd0, 5'd11, 6'h20);
        step();
        chk("r0_A_during_wb", ex_A, 32'd0);
        wb_en = 1'b0;
        step();
        chk("r0_A", ex_A, 32'd0);
        chk("r0_B", ex_B, 32'd0);

        // Same-cycle set/clear on r7: set wins.
        instr   = mk_i(6'h08, 5'd0, 5'd7, 16'h0003);
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h0000_0055;
        step();
        wb_en = 1'b0;
        chk("r7_dest", ex_dest, 5'd7);
        chk("r7_dest_en", ex_dest_en, 1'b1);
        instr = mk_r(5'd7, 5'd0, 5'd12, 6'h20);
        #1 chk("r7_busy0", instr_ready, 1'b0);
        step();
        chk("r7_busy1", instr_ready, 1'b0);
        wb_en   = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h0000_0099;
        #1 chk("r7_clear_ready", instr_ready, 1'b1);
        step();
        wb_en       = 1'b0;
        instr_valid = 1'b0;
        chk("r7_A_bypass", ex_A, 32'h0000_0099);
        chk("r7_use_dest", ex_dest, 5'd12);

        step();
        chk("drain_valid", ex_valid, 1'b0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
